// File: rtl/fast9_pkg.sv
// Shared widths, default geometry and FSM/phase encodings for the FAST9 frame controller.
package fast9_pkg;

   localparam int unsigned AddrW      = 15;
   localparam int unsigned ScoreW     = 8;
   localparam int unsigned DefWidth   = 160;
   localparam int unsigned DefHeight  = 120;
   localparam int unsigned DefBorder  = 3;
   localparam int unsigned DefPipeLat = 2;

   typedef enum logic [2:0] {
      StIdle,
      StClear,
      StDetect,
      StFlush,
      StNms,
      StFin
   } state_e;

   typedef enum logic [1:0] {
      PhIdle   = 2'd0,
      PhClear  = 2'd1,
      PhDetect = 2'd2,
      PhNms    = 2'd3
   } phase_e;

   // FLUSH belongs to the detect phase, FIN to the NMS phase.
   function automatic phase_e state_phase(input state_e s);
      phase_e p;
      case (s)
         StClear:          p = PhClear;
         StDetect, StFlush: p = PhDetect;
         StNms, StFin:     p = PhNms;
         default:          p = PhIdle;
      endcase
      return p;
   endfunction

endpackage

// File: rtl/fast9_interior_scanner.sv
// Raster counter over the interior pixels; wraps to the first pixel after the last one so the
// same instance can run the detect scan and then the NMS rescan.
module fast9_interior_scanner
   import fast9_pkg::*;
#(
   parameter int unsigned WIDTH  = DefWidth,
   parameter int unsigned HEIGHT = DefHeight,
   parameter int unsigned BORDER = DefBorder
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             clear,
   input  logic             enable,
   output logic [AddrW-1:0] addr,
   output logic             last
);

   localparam logic [AddrW-1:0] First     = AddrW'(BORDER);
   localparam logic [AddrW-1:0] XLast     = AddrW'(WIDTH - 1 - BORDER);
   localparam logic [AddrW-1:0] YLast     = AddrW'(HEIGHT - 1 - BORDER);
   localparam logic [AddrW-1:0] AddrFirst = AddrW'(BORDER * WIDTH + BORDER);
   localparam logic [AddrW-1:0] RowStep   = AddrW'(2 * BORDER + 1);

   logic [AddrW-1:0] x_q, y_q, addr_q;
   logic             row_end;

   assign row_end = (x_q == XLast);
   assign last    = row_end && (y_q == YLast);
   assign addr    = addr_q;

   always_ff @(posedge clock) begin
      if (reset) begin
         x_q    <= '0;
         y_q    <= '0;
         addr_q <= '0;
      end else if (clear || (enable && last)) begin
         x_q    <= First;
         y_q    <= First;
         addr_q <= AddrFirst;
      end else if (enable) begin
         if (row_end) begin
            x_q    <= First;
            y_q    <= y_q + AddrW'(1);
            addr_q <= addr_q + RowStep;
         end else begin
            x_q    <= x_q + AddrW'(1);
            addr_q <= addr_q + AddrW'(1);
         end
      end
   end

endmodule

// File: rtl/fast9_frame_ctrl.sv
// Frame sequencer for the FAST9 pipeline: score-memory clear, detect scan with delayed score
// writes, pipeline flush and NMS rescan, owning the single score-memory port.
module fast9_frame_ctrl
   import fast9_pkg::*;
#(
   parameter int unsigned WIDTH    = DefWidth,
   parameter int unsigned HEIGHT   = DefHeight,
   parameter int unsigned BORDER   = DefBorder,
   parameter int unsigned PIPE_LAT = DefPipeLat
) (
   input  logic              clock,
   input  logic              reset,
   input  logic              start,
   input  logic              stall,
   input  logic              isCorner,
   input  logic              fsWren,
   input  logic [ScoreW-1:0] fsValue,
   input  logic [AddrW-1:0]  nmsAddr,
   output logic [AddrW-1:0]  refAddr,
   output logic              refValid,
   output logic [AddrW-1:0]  scoreAddr,
   output logic [ScoreW-1:0] scoreData,
   output logic              scoreWren,
   output logic [1:0]        phase,
   output logic              busy,
   output logic              done,
   output logic [15:0]       cornerCount
);

   localparam int unsigned NPix = WIDTH * HEIGHT;
   localparam int unsigned FlW  = (PIPE_LAT > 1) ? $clog2(PIPE_LAT) : 1;

   state_e            state_q, state_d;
   logic [AddrW-1:0]  clr_q;
   logic [FlW-1:0]    flush_q;
   logic [15:0]       count_q;
   logic [AddrW-1:0]  dl_addr_q [PIPE_LAT];
   logic [PIPE_LAT-1:0] dl_valid_q;
   logic [AddrW-1:0]  scan_addr;
   logic              scan_last, scan_enable;
   logic              accept, run, issue, dl_hit;

   assign accept      = (state_q == StIdle) && start;
   assign run         = (state_q != StIdle) && !stall;
   assign issue       = (state_q == StDetect);
   assign scan_enable = run && ((state_q == StDetect) || (state_q == StNms));
   assign dl_hit      = run && dl_valid_q[PIPE_LAT-1] &&
                        ((state_q == StDetect) || (state_q == StFlush));

   fast9_interior_scanner #(
      .WIDTH  (WIDTH),
      .HEIGHT (HEIGHT),
      .BORDER (BORDER)
   ) u_scanner (
      .clock  (clock),
      .reset  (reset),
      .clear  (accept),
      .enable (scan_enable),
      .addr   (scan_addr),
      .last   (scan_last)
   );

   always_ff @(posedge clock) begin
      if (reset) state_q <= StIdle;
      else       state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      if (state_q == StIdle) begin
         if (start) state_d = StClear;
      end else if (!stall) begin
         unique case (state_q)
            StClear:  if (clr_q == AddrW'(NPix - 1)) state_d = StDetect;
            StDetect: if (scan_last) state_d = StFlush;
            StFlush:  if (flush_q == FlW'(PIPE_LAT - 1)) state_d = StNms;
            StNms:    if (scan_last) state_d = StFin;
            StFin:    state_d = StIdle;
            default:  state_d = StIdle;
         endcase
      end
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         clr_q      <= '0;
         flush_q    <= '0;
         count_q    <= '0;
         dl_valid_q <= '0;
         for (int i = 0; i < PIPE_LAT; i++) dl_addr_q[i] <= '0;
      end else begin
         if (accept) begin
            clr_q   <= '0;
            count_q <= '0;
         end else if (run) begin
            if (state_q == StClear) clr_q <= clr_q + AddrW'(1);
            if (state_q == StFlush) flush_q <= flush_q + FlW'(1);
            else                    flush_q <= '0;
            if (dl_hit && isCorner && (count_q != 16'hFFFF)) count_q <= count_q + 16'd1;
         end
         // Delay line advances with the scan; a stall freezes it in place.
         if (!(stall && (state_q != StIdle))) begin
            dl_addr_q[0]  <= scan_addr;
            dl_valid_q[0] <= issue;
            for (int i = 1; i < PIPE_LAT; i++) begin
               dl_addr_q[i]  <= dl_addr_q[i-1];
               dl_valid_q[i] <= dl_valid_q[i-1];
            end
         end
      end
   end

   always_comb begin
      refAddr     = scan_addr;
      refValid    = ((state_q == StDetect) || (state_q == StNms)) && !stall;
      scoreAddr   = '0;
      scoreData   = '0;
      scoreWren   = 1'b0;
      unique case (state_q)
         StClear: begin
            scoreAddr = clr_q;
            scoreWren = !stall;
         end
         StDetect, StFlush: begin
            scoreAddr = dl_addr_q[PIPE_LAT-1];
            scoreData = fsValue;
            scoreWren = fsWren && dl_valid_q[PIPE_LAT-1] && !stall;
         end
         StNms:   scoreAddr = nmsAddr;
         default: ;
      endcase
      phase       = state_phase(state_q);
      busy        = (state_q != StIdle);
      done        = (state_q == StFin) && !stall;
      cornerCount = count_q;
   end

endmodule
